jt900h_intc: RTL and testbench
==============================

Name: jt900h_intc

Overview:
Parametrised interrupt controller feeding the CPU core's 3-bit `intrq` level input.
- Generalises the fixed 3-line request input to CH sources.
- Each source has a programmable priority and a level/edge trigger mode.
- Tracks pending state and resolves the winning source by priority.
- Completes the acknowledge handshake, returning the winning channel and clearing edge-latched requests.
- Sits between the peripherals and the CPU core; configured over a small byte-wide register port.

Parameters:
CH, 8, number of interrupt sources (1..32).
CHW, 3, channel index width; must satisfy 2^CHW >= CH.
RSTMODE, 0, reset trigger mode of every channel (0 = level, 1 = rising edge).

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
cen  in  1  clock enable; all state advances only when cen=1
src  in  CH  interrupt request lines, synchronous to clk, active-high
cfg_we  in  1  configuration write strobe
cfg_addr  in  CHW  channel register select
cfg_din  in  8  configuration write data
cfg_dout  out  8  register read data for cfg_addr (combinational)
intrq  out  3  winning priority level to the CPU; 0 = no request
int_ch  out  CHW  channel index of the current winner
irq_ack  in  1  CPU accepts the interrupt at the currently presented level
ack_ch  out  CHW  channel captured at acknowledge
ack_vld  out  1  one-cen-cycle pulse; ack_ch is valid

Behaviour:
- Interface: one clock `clk`; synchronous active-high reset `rst`. While rst=1, all state clears on the clock edge regardless of cen.
- Reset values:
  - intrq=0, int_ch=0, ack_ch=0, ack_vld=0.
  - Every channel: prio=0, pending=0, mode=RSTMODE, src history=0.
- Channel register (cfg_addr=n, n<CH):
  - [2:0] prio. 0 disables the channel: it can still go pending but never wins.
  - [3] mode: 1 = edge, 0 = level.
  - [6:4] read 0.
  - [7] pending: read returns the pending state. Writing 0 clears pending (edge mode only). Writing 1 has no effect.
  - cfg_addr>=CH: writes ignored, reads return 0.
- Edge mode:
  - src[n] is registered each cen cycle.
  - A rising edge (src=1, previous=0) sets pending on the next cen edge.
  - Pending holds until acked or cleared by a write.
- Level mode: pending = registered src[n]; ack and writes do not clear it.
- Arbitration:
  - Candidate = pending & (prio!=0).
  - Winner = highest prio; ties go to the lowest channel index.
  - intrq and int_ch are registered from the arbitration result.
  - Latency: src rising at cen edge k → pending at k+1 → intrq valid at k+2.
- Acknowledge (irq_ack=1 with cen=1):
  - ack_ch <= int_ch and ack_vld=1 for exactly one cen cycle.
  - If the winner is edge mode, its pending clears.
  - irq_ack while intrq=0: ack_vld still pulses, ack_ch=int_ch; no state changes.
  - irq_ack is ignored while ack_vld=1; back-to-back acks need one idle cen cycle.
- Simultaneous events:
  - A new edge on the same cycle as its ack-clear or write-clear leaves pending set (set wins).
  - A config write changing prio takes effect on the arbitration in the following cycle.
- cen=0: every register holds; ack_vld holds its value.

Decomposition:
- Shared package jt900h_intc_pkg holds:
  - field offsets: PRIO_LSB=0, PRIO_W=3, MODE_BIT=3, PEND_BIT=7;
  - mode constants: MODE_LEVEL=0, MODE_EDGE=1;
  - priority width constant 3, matching the CPU intrq width.
- One sub-module, jt900h_intc_ch, instantiated CH times. It contains the per-channel prio/mode registers, the src history flop, edge detect, pending set/clear with set-wins, and read-data formatting.
- The top level holds the combinational priority tree, the output registers and the ack logic.

Test Plan:
1. Reset, then write ch2 prio=5 mode=edge. Pulse src[2] for 1 cen → intrq=5, int_ch=2 two cen cycles after the edge. irq_ack → ack_vld=1, ack_ch=2; next cycle intrq=0 and cfg_dout bit7=0.
2. ch1 prio=3 level, ch6 prio=6 level, both src held high → intrq=6, int_ch=6. Drop src[6] → intrq=3, int_ch=1. irq_ack → ack_ch=1, and intrq stays 3 while src[1]=1.
3. Tie: ch0 and ch4 both prio=4 edge, edges on the same cycle → int_ch=0. Ack → int_ch=4, intrq=4. Second ack → intrq=0.
4. ch3 prio=0, edge on src[3] → pending reads 1 and intrq stays 0. Write prio=2 → intrq=2 on the following cycle.
5. Set-wins check: ch5 edge pending, prio=7. Issue irq_ack on the same cen edge as a new src[5] rising edge → ack_vld=1, ack_ch=5, and pending remains 1 (intrq=7).
6. cen held 0 for 10 cycles during an ack and an edge → no output changes. Assert rst mid-pending → all outputs 0 and every cfg_dout reads RSTMODE<<3.

Source files
------------

// File: rtl/jt900h_intc_pkg.sv
// Shared field layout, trigger-mode type and read-data formatting for the
// jt900h interrupt controller and its per-channel slices.
package jt900h_intc_pkg;

    localparam int INTRQ_W  = 3;
    localparam int PRIO_W   = INTRQ_W;
    localparam int PRIO_LSB = 0;
    localparam int MODE_BIT = 3;
    localparam int PEND_BIT = 7;
    localparam int REG_W    = 8;

    typedef enum logic {
        MODE_LEVEL = 1'b0,
        MODE_EDGE  = 1'b1
    } mode_e;

    // Channel register image as seen on cfg_dout; unused bits read as zero.
    function automatic logic [REG_W-1:0] fmt_rd(
        input logic [PRIO_W-1:0] prio,
        input mode_e             mode,
        input logic              pend
    );
        logic [REG_W-1:0] r;
        r                      = '0;
        r[PRIO_LSB +: PRIO_W]  = prio;
        r[MODE_BIT]            = logic'(mode);
        r[PEND_BIT]            = pend;
        return r;
    endfunction

endpackage

// File: rtl/jt900h_intc_ch.sv
// One interrupt source: priority/mode registers, request history, edge
// detection and the pending flag, plus its register read image.
module jt900h_intc_ch
    import jt900h_intc_pkg::*;
#(
    parameter int RSTMODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen,
    input  logic              src,
    input  logic              wr_en,
    input  logic [PRIO_W-1:0] wr_prio,
    input  logic              wr_mode,
    input  logic              wr_pend,
    input  logic              ack_clr,
    output logic [PRIO_W-1:0] prio,
    output logic              pend,
    output logic [REG_W-1:0]  rd_data
);

    localparam mode_e RST_MODE = (RSTMODE != 0) ? MODE_EDGE : MODE_LEVEL;

    logic [PRIO_W-1:0] prio_q, prio_d;
    mode_e             mode_q, mode_d;
    logic              src_q, src_d;
    logic              pend_q, pend_d;
    logic              rise;
    logic              clr;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        prio_d = prio_q;
        mode_d = mode_q;
        src_d  = src_q;
        pend_d = pend_q;
        rise   = src & ~src_q;
        clr    = (ack_clr | (wr_en & ~wr_pend)) & (mode_q == MODE_EDGE);

        if (cen) begin
            src_d = src;
            if (wr_en) begin
                prio_d = wr_prio;
                mode_d = mode_e'(wr_mode);
            end
            // A fresh edge beats a clear landing on the same cycle.
            if (mode_q == MODE_EDGE) begin
                pend_d = rise | (pend_q & ~clr);
            end else begin
                pend_d = src;
            end
        end
    end

    // NOTE: state flops use non-blocking assignments only; the blocking '='
    // above is confined to combinational next-state logic.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= '0;
            mode_q <= RST_MODE;
            src_q  <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
            mode_q <= mode_d;
            src_q  <= src_d;
            pend_q <= pend_d;
        end
    end

    assign prio    = prio_q;
    assign pend    = pend_q;
    assign rd_data = fmt_rd(prio_q, mode_q, pend_q);

endmodule

// File: rtl/jt900h_intc.sv
// Interrupt controller in front of the jt900h core: CH prioritised sources
// resolved to a registered 3-bit intrq level with an acknowledge handshake.
module jt900h_intc
    import jt900h_intc_pkg::*;
#(
    parameter int CH      = 8,
    parameter int CHW     = 3,
    parameter int RSTMODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cen,
    input  logic [CH-1:0]      src,
    input  logic               cfg_we,
    input  logic [CHW-1:0]     cfg_addr,
    input  logic [REG_W-1:0]   cfg_din,
    output logic [REG_W-1:0]   cfg_dout,
    output logic [INTRQ_W-1:0] intrq,
    output logic [CHW-1:0]     int_ch,
    input  logic               irq_ack,
    output logic [CHW-1:0]     ack_ch,
    output logic               ack_vld
);

    logic [PRIO_W-1:0]  ch_prio [CH];
    logic [REG_W-1:0]   ch_rd   [CH];
    logic [CH-1:0]      ch_pend;
    logic [CH-1:0]      ch_we;
    logic [CH-1:0]      ch_ack_clr;

    logic               ack_fire;
    logic [INTRQ_W-1:0] best_prio;
    logic [CHW-1:0]     best_ch;

    logic [INTRQ_W-1:0] intrq_q, intrq_d;
    logic [CHW-1:0]     int_ch_q, int_ch_d;
    logic [CHW-1:0]     ack_ch_q, ack_ch_d;
    logic               ack_vld_q, ack_vld_d;
    logic               unused_cfg_bits;

    assign unused_cfg_bits = ^cfg_din[PEND_BIT-1:MODE_BIT+1];

    // An ack right after an accepted one is dropped: intrq is still stale.
    assign ack_fire = cen & irq_ack & ~ack_vld_q;

    for (genvar n = 0; n < CH; n++) begin : g_ch
        assign ch_we[n]      = cen & cfg_we & (cfg_addr == CHW'(n));
        assign ch_ack_clr[n] = ack_fire & (intrq_q != '0) & (int_ch_q == CHW'(n));

        jt900h_intc_ch #(
            .RSTMODE (RSTMODE)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .cen     (cen),
            .src     (src[n]),
            .wr_en   (ch_we[n]),
            .wr_prio (cfg_din[PRIO_LSB +: PRIO_W]),
            .wr_mode (cfg_din[MODE_BIT]),
            .wr_pend (cfg_din[PEND_BIT]),
            .ack_clr (ch_ack_clr[n]),
            .prio    (ch_prio[n]),
            .pend    (ch_pend[n]),
            .rd_data (ch_rd[n])
        );
    end

    // Strict '>' while scanning upwards keeps the lowest index on ties;
    // prio 0 can never beat the initial best of 0.
    always_comb begin
        best_prio = '0;
        best_ch   = '0;
        for (int i = 0; i < CH; i++) begin
            if (ch_pend[i] && (ch_prio[i] > best_prio)) begin
                best_prio = ch_prio[i];
                best_ch   = CHW'(i);
            end
        end
    end

    always_comb begin
        cfg_dout = '0;
        for (int i = 0; i < CH; i++) begin
            if (cfg_addr == CHW'(i)) begin
                cfg_dout = ch_rd[i];
            end
        end
    end

    always_comb begin
        intrq_d   = intrq_q;
        int_ch_d  = int_ch_q;
        ack_ch_d  = ack_ch_q;
        ack_vld_d = ack_vld_q;
        if (cen) begin
            intrq_d   = best_prio;
            int_ch_d  = best_ch;
            ack_vld_d = ack_fire;
            if (ack_fire) begin
                ack_ch_d = int_ch_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            intrq_q   <= '0;
            int_ch_q  <= '0;
            ack_ch_q  <= '0;
            ack_vld_q <= 1'b0;
        end else begin
            intrq_q   <= intrq_d;
            int_ch_q  <= int_ch_d;
            ack_ch_q  <= ack_ch_d;
            ack_vld_q <= ack_vld_d;
        end
    end

    assign intrq   = intrq_q;
    assign int_ch  = int_ch_q;
    assign ack_ch  = ack_ch_q;
    assign ack_vld = ack_vld_q;

endmodule

// File: tb/tb_jt900h_intc.sv
// Directed bench for jt900h_intc: expected intrq/int_ch transitions and ack
// events are queued by the stimulus and popped by an independent monitor.
module tb_jt900h_intc;

    localparam int CH      = 8;
    localparam int CHW     = 3;
    localparam int RSTMODE = 0;

    logic           clk = 1'b0;
    logic           rst;
    logic           cen;
    logic [CH-1:0]  src;
    logic           cfg_we;
    logic [CHW-1:0] cfg_addr;
    logic [7:0]     cfg_din;
    logic [7:0]     cfg_dout;
    logic [2:0]     intrq;
    logic [CHW-1:0] int_ch;
    logic           irq_ack;
    logic [CHW-1:0] ack_ch;
    logic           ack_vld;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct packed {
        logic [2:0]     lvl;
        logic [CHW-1:0] ch;
    } lvl_t;

    lvl_t           lvl_q[$];
    logic [CHW-1:0] ack_q[$];

    jt900h_intc #(
        .CH      (CH),
        .CHW     (CHW),
        .RSTMODE (RSTMODE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cen      (cen),
        .src      (src),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_din  (cfg_din),
        .cfg_dout (cfg_dout),
        .intrq    (intrq),
        .int_ch   (int_ch),
        .irq_ack  (irq_ack),
        .ack_ch   (ack_ch),
        .ack_vld  (ack_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic lvl_t mk(input int l, input int c);
        return {3'(l), CHW'(c)};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write(input int a, input logic [7:0] d);
        cfg_we   = 1'b1;
        cfg_addr = CHW'(a);
        cfg_din  = d;
        step(1);
        cfg_we   = 1'b0;
    endtask

    task automatic rd_check(input string name, input int a, input logic [7:0] exp);
        cfg_addr = CHW'(a);
        #1;
        check(name, cfg_dout, exp);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        cen      = 1'b1;
        src      = '0;
        cfg_we   = 1'b0;
        cfg_addr = '0;
        cfg_din  = '0;
        irq_ack  = 1'b0;
        step(2);
        rst      = 1'b0;
    endtask

    // Monitor: every change of {intrq,int_ch} and every ack_vld pulse outside
    // reset must match the next queued expectation.
    initial begin
        lvl_t prev_lvl;
        logic prev_vld;
        lvl_t e;
        prev_lvl = '0;
        prev_vld = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if ({intrq, int_ch} !== prev_lvl) begin
                    if (lvl_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL mon_lvl: unexpected change to intrq=%0d int_ch=%0d", intrq, int_ch);
                    end else begin
                        e = lvl_q.pop_front();
                        check("mon_lvl", {intrq, int_ch}, e);
                    end
                end
                if (ack_vld && !prev_vld) begin
                    if (ack_q.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL mon_ack: unexpected ack_vld with ack_ch=%0d", ack_ch);
                    end else begin
                        check("mon_ack_ch", ack_ch, ack_q.pop_front());
                    end
                end
            end
            prev_lvl = {intrq, int_ch};
            prev_vld = ack_vld;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n_diff;

        // 1: edge source, latency, ack clears pending
        do_reset();
        check("rst_intrq", intrq, 0);
        check("rst_int_ch", int_ch, 0);
        check("rst_ack_ch", ack_ch, 0);
        check("rst_ack_vld", ack_vld, 0);
        write(2, 8'h0D);
        lvl_q.push_back(mk(5, 2));
        src[2] = 1'b1;
        step(1);
        src[2] = 1'b0;
        check("t1_intrq_k1", intrq, 0);
        rd_check("t1_pend_set", 2, 8'h8D);
        step(1);
        check("t1_intrq", intrq, 5);
        check("t1_int_ch", int_ch, 2);
        ack_q.push_back(3'd2);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        check("t1_ack_vld", ack_vld, 1);
        lvl_q.push_back(mk(0, 0));
        step(1);
        check("t1_intrq_clr", intrq, 0);
        rd_check("t1_pend_clr", 2, 8'h0D);

        // 2: level sources, priority order, ack does not clear level
        do_reset();
        write(1, 8'h03);
        write(6, 8'h06);
        lvl_q.push_back(mk(6, 6));
        src[1] = 1'b1;
        src[6] = 1'b1;
        step(2);
        check("t2_intrq_hi", intrq, 6);
        check("t2_int_ch_hi", int_ch, 6);
        lvl_q.push_back(mk(3, 1));
        src[6] = 1'b0;
        step(2);
        check("t2_intrq_lo", intrq, 3);
        check("t2_int_ch_lo", int_ch, 1);
        ack_q.push_back(3'd1);
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        check("t2_ack_ch", ack_ch, 1);
        step(2);
        check("t2_level_hold", intrq, 3);
        rd_check("t2_level_pend", 1, 8'h83);

        // 3: tie to lowest index, held ack ignored on the second cycle
        do_reset();
        write(0, 8'h0C);
        write(4, 8'h0C);
        lvl_q.push_back(mk(4, 0));
        src[0] = 1'b1;
        src[4] = 1'b1;
        step(1);
        src = '0;
        step(1);
        check("t3_tie_ch", int_ch, 0);
        check("t3_tie_lvl", intrq, 4);
        ack_q.push_back(3'd0);
        lvl_q.push_back(mk(4, 4));
        irq_ack = 1'b1;
        step(2);
        irq_ack = 1'b0;
        check("t3_ack_ignored", ack_vld, 0);
        check("t3_next_ch", int_ch, 4);
        check("t3_next_lvl", intrq, 4);
        ack_q.push_back(3'd4);
        lvl_q.push_back(mk(0, 0));
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        step(1);
        check("t3_all_clr", intrq, 0);

        // 4: prio 0 pends but never wins; prio write acts the cycle after
        do_reset();
        write(3, 8'h08);
        src[3] = 1'b1;
        step(1);
        src[3] = 1'b0;
        step(2);
        rd_check("t4_pend_p0", 3, 8'h88);
        check("t4_no_win", intrq, 0);
        lvl_q.push_back(mk(2, 3));
        write(3, 8'h8A);
        check("t4_prio_delay", intrq, 0);
        step(1);
        check("t4_prio_lvl", intrq, 2);
        check("t4_prio_ch", int_ch, 3);

        // 5: new edge on the ack cycle keeps pending
        do_reset();
        write(5, 8'h0F);
        lvl_q.push_back(mk(7, 5));
        src[5] = 1'b1;
        step(1);
        src[5] = 1'b0;
        step(1);
        check("t5_intrq", intrq, 7);
        ack_q.push_back(3'd5);
        src[5]  = 1'b1;
        irq_ack = 1'b1;
        step(1);
        irq_ack = 1'b0;
        rd_check("t5_set_wins", 5, 8'h8F);
        src[5] = 1'b0;
        step(2);
        check("t5_intrq_hold", intrq, 7);
        check("t5_int_ch_hold", int_ch, 5);

        // 6: cen low freezes everything, then reset with cen still low
        cen      = 1'b0;
        irq_ack  = 1'b1;
        src[5]   = 1'b1;
        src[0]   = 1'b1;
        cfg_we   = 1'b1;
        cfg_addr = 3'd5;
        cfg_din  = 8'h00;
        n_diff   = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (intrq !== 3'd7 || int_ch !== 3'd5 || ack_vld !== 1'b0 || ack_ch !== 3'd5)
                n_diff++;
        end
        check("t6_cen_hold", n_diff, 0);
        cfg_we  = 1'b0;
        irq_ack = 1'b0;
        rd_check("t6_cfg_hold", 5, 8'h8F);
        rst = 1'b1;
        step(1);
        check("t6_rst_intrq", intrq, 0);
        check("t6_rst_int_ch", int_ch, 0);
        check("t6_rst_ack_ch", ack_ch, 0);
        check("t6_rst_ack_vld", ack_vld, 0);
        for (int a = 0; a < CH; a++)
            rd_check($sformatf("t6_rst_reg%0d", a), a, 8'(RSTMODE << 3));
        src = '0;
        cen = 1'b1;
        rst = 1'b0;
        step(3);

        check("lvl_q_drained", lvl_q.size(), 0);
        check("ack_q_drained", ack_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
